// File: rtl/layer_ram_pkg.sv
// Shared types for the layer-RAM path (arbiter, read cache, SDRAM controller wrapper).
// tag_of packs {layer, addr >> index_w} right-aligned in the widest possible tag.
package layer_ram_pkg;
  localparam int LAYER_W             = 6;
  localparam int ADDR_W              = 24;
  localparam int DATA_W              = 16;
  localparam int CACHE_DEPTH_DEFAULT = 32;
  localparam int TAG_MAX_W           = LAYER_W + ADDR_W;

  typedef logic [LAYER_W-1:0]   layer_t;
  typedef logic [ADDR_W-1:0]    word_addr_t;
  typedef logic [DATA_W-1:0]    word_t;
  typedef logic [TAG_MAX_W-1:0] tag_max_t;

  // The low LAYER_W+ADDR_W-index_w bits of the result form the cache tag.
  function automatic tag_max_t tag_of(input layer_t layer, input word_addr_t addr,
                                      input int unsigned index_w);
    tag_max_t t;
    t = (tag_max_t'(layer) << (ADDR_W - index_w)) | tag_max_t'(addr >> index_w);
    return t;
  endfunction
endpackage

// File: rtl/layer_ram_cache.sv
// Direct-mapped one-word-per-entry read cache for layer pixel data.
// Combinational lookup; fills overwrite the indexed entry; rst low flushes everything.
module layer_ram_cache
  import layer_ram_pkg::*;
#(
  parameter int CACHE_DEPTH = CACHE_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [LAYER_W-1:0] layer,
  input  logic [ADDR_W-1:0] addr_words,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_o_valid
);
  localparam int INDEX_W = $clog2(CACHE_DEPTH);
  localparam int TAG_W   = LAYER_W + ADDR_W - INDEX_W;

  logic [CACHE_DEPTH-1:0] valid;
  logic [TAG_W-1:0]       tag_mem  [CACHE_DEPTH];
  logic [DATA_W-1:0]      data_mem [CACHE_DEPTH];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   cur_tag;
  logic               hit;

  assign idx     = addr_words[INDEX_W-1:0];
  assign cur_tag = {layer, addr_words[ADDR_W-1:INDEX_W]};

  // The async clear holds valid at 0 for as long as rst is low, so fills are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          valid      <= '0;
    else if (write_en) valid[idx] <= 1'b1;
  end

  // Tag/data may be written during reset: the entry stays invalid until a real fill
  // rewrites both fields, so no reset gating is needed here.
  always_ff @(posedge clk) begin
    if (write_en) begin
      tag_mem[idx]  <= cur_tag;
      data_mem[idx] <= data_i;
    end
  end

  assign hit          = valid[idx] && (tag_mem[idx] == cur_tag);
  assign data_o_valid = hit;
  assign data_o       = hit ? data_mem[idx] : '0;
endmodule

// File: tb/tb_layer_ram_cache.sv
// Randomized self-checking bench for layer_ram_cache against a keyed-entry reference model.
`timescale 1ns/1ps
module tb_layer_ram_cache;
  import layer_ram_pkg::*;

  localparam int DEPTH = 32;

  logic   clk = 1'b0;
  logic   rst;
  logic   write_en;
  layer_t layer;
  word_addr_t addr_words;
  word_t  data_i;
  word_t  data_o;
  logic   data_o_valid;

  int total = 0;
  int bad   = 0;

  // Model: each slot remembers the full (layer, address) that last filled it.
  bit         m_vld  [DEPTH];
  layer_t     m_layer[DEPTH];
  word_addr_t m_addr [DEPTH];
  word_t      m_data [DEPTH];

  layer_ram_cache #(.CACHE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .layer(layer),
    .addr_words(addr_words), .data_i(data_i), .data_o(data_o),
    .data_o_valid(data_o_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int slot_of(input word_addr_t a);
    return int'(a) % DEPTH;
  endfunction

  function automatic bit m_hit(input layer_t l, input word_addr_t a);
    int s = slot_of(a);
    return m_vld[s] && m_layer[s] == l && m_addr[s] == a;
  endfunction

  task automatic m_flush();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
  endtask

  task automatic check_lookup(input string tag);
    bit    h = m_hit(layer, addr_words);
    word_t d = h ? m_data[slot_of(addr_words)] : word_t'(0);
    chk({tag, ".vld"}, 32'(data_o_valid), 32'(h));
    chk({tag, ".dat"}, 32'(data_o), 32'(d));
  endtask

  // One cycle: drive on negedge, check the pre-edge lookup, then commit the model at the edge.
  task automatic step(input string tag, input logic we, input layer_t l,
                      input word_addr_t a, input word_t d);
    @(negedge clk);
    write_en = we; layer = l; addr_words = a; data_i = d;
    #1 check_lookup(tag);
    @(posedge clk);
    if (we && rst) begin
      int s = slot_of(a);
      m_vld[s] = 1'b1; m_layer[s] = l; m_addr[s] = a; m_data[s] = d;
    end
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < DEPTH; i++)
      if (m_vld[i]) step(tag, 1'b0, m_layer[i], m_addr[i], word_t'($urandom));
  endtask

  initial begin
    m_flush();
    rst = 1'b0; write_en = 1'b0; layer = '0; addr_words = '0; data_i = '0;

    // Reset held for two cycles, a fill attempted while held must be dropped.
    step("rst_hold", 1'b1, layer_t'(3), word_addr_t'(24'h000005), word_t'(16'hAAAA));
    step("rst_hold2", 1'b0, layer_t'(0), word_addr_t'(0), word_t'(0));
    @(negedge clk); rst = 1'b1;
    step("rst_l0", 1'b0, layer_t'(0), word_addr_t'(0), word_t'(0));
    step("rst_l3", 1'b0, layer_t'(3), word_addr_t'(24'h000005), word_t'(0));
    chk("rst_l3.vld_const", 32'(data_o_valid), 32'd0);

    // Fill / hit, same-cycle lookup sees the old contents.
    step("fill_same_cyc", 1'b1, layer_t'(3), word_addr_t'(24'h000105), word_t'(16'hBEEF));
    step("fill_hit", 1'b0, layer_t'(3), word_addr_t'(24'h000105), word_t'(0));
    chk("fill_hit.data_const", 32'(data_o), 32'h0000BEEF);
    step("miss_layer", 1'b0, layer_t'(4), word_addr_t'(24'h000105), word_t'(0));
    step("miss_upper", 1'b0, layer_t'(3), word_addr_t'(24'h000125), word_t'(0));

    // Eviction by an aliasing address.
    step("evict_fill", 1'b1, layer_t'(3), word_addr_t'(24'h000125), word_t'(16'h1234));
    step("evict_new", 1'b0, layer_t'(3), word_addr_t'(24'h000125), word_t'(0));
    chk("evict_new.data_const", 32'(data_o), 32'h00001234);
    step("evict_old", 1'b0, layer_t'(3), word_addr_t'(24'h000105), word_t'(0));

    // Sweep every index.
    for (int a = 'h200; a < 'h220; a++)
      step("sweep_fill", 1'b1, layer_t'(0), word_addr_t'(a), word_t'(a));
    readback("sweep_rd");

    // Random mix: few layers and few upper-address patterns to force aliasing.
    for (int n = 0; n < 400; n++) begin
      word_addr_t a = word_addr_t'(($urandom_range(0, 3) << 5) | $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a[ADDR_W-1] = 1'b1;
      step("rand", 1'($urandom_range(0, 1)), layer_t'($urandom_range(0, 2)), a,
           word_t'($urandom));
    end
    readback("rand_rd");

    // Async flush: half-period low pulse covering a rising edge with write_en=1.
    @(negedge clk);
    write_en = 1'b1; layer = layer_t'(7); addr_words = word_addr_t'(24'h0ABC07);
    data_i = word_t'(16'h5A5A);
    #1 rst = 1'b0;
    #0.5;
    for (int i = 0; i < 4; i++) begin
      if (m_vld[i]) begin
        layer = m_layer[i]; addr_words = m_addr[i];
        #0.5 chk("flush_vld", 32'(data_o_valid), 32'd0);
        chk("flush_dat", 32'(data_o), 32'd0);
      end
    end
    layer = layer_t'(7); addr_words = word_addr_t'(24'h0ABC07);
    m_flush();
    @(posedge clk);
    #1 rst = 1'b1;
    step("flush_pulse_wr", 1'b0, layer_t'(7), word_addr_t'(24'h0ABC07), word_t'(0));
    step("post_fill", 1'b1, layer_t'(9), word_addr_t'(24'h000210), word_t'(16'hC0DE));
    step("post_hit", 1'b0, layer_t'(9), word_addr_t'(24'h000210), word_t'(0));
    chk("post_hit.vld_const", 32'(data_o_valid), 32'd1);

    // Refill some entries, idle with write_en=0 and wiggling inputs, then read back.
    for (int n = 0; n < 16; n++)
      step("refill", 1'b1, layer_t'($urandom_range(0, 63)), word_addr_t'($urandom),
           word_t'($urandom));
    for (int n = 0; n < 10; n++)
      step("idle", 1'b0, layer_t'($urandom_range(0, 63)), word_addr_t'($urandom),
           word_t'($urandom));
    readback("idle_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
